// File: rtl/rand_roll.sv
// Debounced push-button die roller: captures a random byte on a clean press,
// reduces it modulo SIDES by repeated subtraction and shows the face as a thermometer bar.
module rand_roll #(
    parameter int unsigned SIDES           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] rand_in,
    input  logic       key_n,
    output logic [9:0] led,
    output logic [3:0] roll_value,
    output logic       roll_valid,
    output logic       busy
);

    typedef enum logic {StIdle, StReduce} state_e;

    localparam logic [7:0] SidesB = 8'(SIDES);
    localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

    state_e     state_q, state_d;
    logic       key_meta_q, key_meta_d;
    logic       key_s_q, key_s_d;
    logic       stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [9:0] led_q, led_d;
    logic [3:0] roll_q, roll_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       press;
    logic [9:0] therm;

    always_comb begin
        key_meta_d = key_n;
        key_s_d    = key_meta_q;
        stable_d   = stable_q;
        cnt_d      = 8'd0;
        // Level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample
        if (key_s_q != stable_q) begin
            if (cnt_q == DbLast) begin
                stable_d = key_s_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        press = stable_q & ~stable_d;
    end

    always_comb begin
        therm = '0;
        for (int k = 0; k < 10; k++) begin
            therm[k] = (8'(k) <= acc_q);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        led_d   = led_q;
        roll_d  = roll_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            StIdle: begin
                if (press) begin
                    acc_d   = rand_in;
                    busy_d  = 1'b1;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (acc_q >= SidesB) begin
                    acc_d = acc_q - SidesB;
                end else begin
                    roll_d  = acc_q[3:0] + 4'd1;
                    led_d   = therm;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            stable_q   <= 1'b1;
            cnt_q      <= 8'd0;
            acc_q      <= 8'd0;
            led_q      <= 10'd0;
            roll_q     <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_meta_q <= key_meta_d;
            key_s_q    <= key_s_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            led_q      <= led_d;
            roll_q     <= roll_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign led        = led_q;
    assign roll_value = roll_q;
    assign roll_valid = valid_q;
    assign busy       = busy_q;

endmodule
